// File: rtl/decryptor_pkg.sv
// decryptor_pkg: shared state encoding, width defaults and rotate helper for the stream decryptor
package decryptor_pkg;
  localparam int BLOCK_W_DEF = 128;
  localparam int CTR_W_DEF = 32;
  localparam int MAX_W = 1024;
  typedef enum logic [1:0] {IDLE, ABSORB, RESP} state_t;
  // Width-generic rotate: callers zero-extend to MAX_W and truncate the result back to their width.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] value, input int unsigned amount,
                                            input int unsigned width = BLOCK_W_DEF);
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << width) - MAX_W'(1);
    return ((value << amount) | (value >> (width - amount))) & mask;
  endfunction
endpackage

// File: rtl/stream_decryptor_if.sv
// stream_decryptor_if: config, request-beat and response bundle; DECRYPTOR_MAC_CHECK_EN adds tag/auth signals
interface stream_decryptor_if #(
  parameter int BLOCK_W = 128,
  parameter int NUM_BLOCKS = 5,
  parameter int CTR_W = 32
);
  localparam int NB_W = $clog2(NUM_BLOCKS + 1);
  logic [BLOCK_W-1:0] cfg_key;
  logic [BLOCK_W-CTR_W-1:0] cfg_nonce;
  logic [BLOCK_W-1:0] req_ct;
  logic req_last;
  logic req_val;
  logic req_rdy;
  logic [NUM_BLOCKS*BLOCK_W-1:0] resp_plaintext;
  logic [NB_W-1:0] resp_nblk;
  logic resp_trunc;
  logic [BLOCK_W-1:0] resp_hmac;
  logic resp_val;
  logic resp_rdy;
`ifdef DECRYPTOR_MAC_CHECK_EN
  logic [BLOCK_W-1:0] req_tag;
  logic resp_auth_ok;
`endif
  modport master (
`ifdef DECRYPTOR_MAC_CHECK_EN
    output req_tag, input resp_auth_ok,
`endif
    output cfg_key, cfg_nonce, req_ct, req_last, req_val, resp_rdy,
    input req_rdy, resp_plaintext, resp_nblk, resp_trunc, resp_hmac, resp_val
  );
  modport slave (
`ifdef DECRYPTOR_MAC_CHECK_EN
    input req_tag, output resp_auth_ok,
`endif
    input cfg_key, cfg_nonce, req_ct, req_last, req_val, resp_rdy,
    output req_rdy, resp_plaintext, resp_nblk, resp_trunc, resp_hmac, resp_val
  );
endinterface

// File: rtl/stream_decryptor_ctr_keystream.sv
// ctr_keystream: combinational counter-mode keystream block from key, nonce and beat counter
module ctr_keystream import decryptor_pkg::*; #(
  parameter int BLOCK_W = BLOCK_W_DEF,
  parameter int CTR_W = CTR_W_DEF
) (
  input  logic [BLOCK_W-1:0] key,
  input  logic [BLOCK_W-CTR_W-1:0] nonce,
  input  logic [CTR_W-1:0] ctr,
  output logic [BLOCK_W-1:0] ks
);
  logic [BLOCK_W-1:0] cb;
  assign cb = {nonce, ctr};
  assign ks = key ^ cb ^ BLOCK_W'(rotl(MAX_W'(cb), 1, BLOCK_W));
endmodule

// File: rtl/stream_decryptor.sv
// stream_decryptor: streams ciphertext beats through a CTR keystream, packs plaintext and folds a rotate-xor MAC.
// DECRYPTOR_MAC_CHECK_EN adds req_tag input and resp_auth_ok output.
module stream_decryptor import decryptor_pkg::*; #(
  parameter int BLOCK_W = BLOCK_W_DEF,
  parameter int NUM_BLOCKS = 5,
  parameter int CTR_W = CTR_W_DEF
) (
  input logic clk,
  input logic rst,
  stream_decryptor_if.slave bus
);
  localparam int NB_W = $clog2(NUM_BLOCKS + 1);
  state_t state, nxt;
  logic [CTR_W-1:0] ctr;
  logic [BLOCK_W-1:0] key_q, mac_q, key_use, mac_nxt, ks, pt_beat;
  logic [BLOCK_W-CTR_W-1:0] nonce_q, nonce_use;
  logic [NUM_BLOCKS*BLOCK_W-1:0] pt_q;
  logic [NB_W-1:0] nblk_q;
  logic trunc_q, acc, at_max, term;
  // Beat 0 uses cfg_* directly so the first beat needs no extra cycle; later beats use the latched copy.
  assign key_use = state == IDLE ? bus.cfg_key : key_q;
  assign nonce_use = state == IDLE ? bus.cfg_nonce : nonce_q;
  assign acc = bus.req_val && bus.req_rdy;
  assign at_max = ctr == CTR_W'(NUM_BLOCKS - 1);
  assign term = acc && (bus.req_last || at_max);
  assign mac_nxt = BLOCK_W'(rotl(MAX_W'(state == IDLE ? bus.cfg_key : mac_q), 7, BLOCK_W)) ^ bus.req_ct;
  assign pt_beat = bus.req_ct ^ ks;
  ctr_keystream #(.BLOCK_W(BLOCK_W), .CTR_W(CTR_W)) u_ks (
    .key(key_use), .nonce(nonce_use), .ctr(ctr), .ks(ks)
  );
  always_comb begin
    nxt = state;
    if (state == IDLE && acc) nxt = term ? RESP : ABSORB;
    else if (state == ABSORB && term) nxt = RESP;
    else if (state == RESP && bus.resp_rdy) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ctr <= '0;
      key_q <= '0;
      nonce_q <= '0;
      mac_q <= '0;
      pt_q <= '0;
      nblk_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      state <= nxt;
      if (acc) begin
        if (state == IDLE) begin
          key_q <= bus.cfg_key;
          nonce_q <= bus.cfg_nonce;
          pt_q <= '0;
        end
        for (int b = 0; b < NUM_BLOCKS; b++)
          if (CTR_W'(b) == ctr) pt_q[b*BLOCK_W +: BLOCK_W] <= pt_beat;
        ctr <= term ? '0 : ctr + CTR_W'(1);
        mac_q <= mac_nxt;
        nblk_q <= NB_W'(ctr + CTR_W'(1));
        trunc_q <= !bus.req_last && at_max;
      end
    end
  end
`ifdef DECRYPTOR_MAC_CHECK_EN
  logic auth_q;
  always_ff @(posedge clk) begin
    if (rst) auth_q <= 1'b0;
    else if (term) auth_q <= mac_nxt == bus.req_tag;
  end
  assign bus.resp_auth_ok = auth_q;
`endif
  assign bus.req_rdy = state != RESP;
  assign bus.resp_val = state == RESP;
  assign bus.resp_plaintext = pt_q;
  assign bus.resp_nblk = nblk_q;
  assign bus.resp_trunc = trunc_q;
  assign bus.resp_hmac = mac_q;
endmodule
